// File: rtl/arb_mux2_stream_if.sv
// Two-source / one-sink stream bundle for arb_mux2_stream.
// The slave modport is the arbiter side, master is the environment side.
interface arb_mux2_stream_if #(
    parameter int width = 8
);
    logic [width-1:0] d0;
    logic             d0_valid;
    logic             d0_ready;
    logic [width-1:0] d1;
    logic             d1_valid;
    logic             d1_ready;
    logic [width-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             y_src;

    modport slave (
        input  d0,
        input  d0_valid,
        output d0_ready,
        input  d1,
        input  d1_valid,
        output d1_ready,
        output y,
        output y_valid,
        input  y_ready,
        output y_src
    );

    modport master (
        output d0,
        output d0_valid,
        input  d0_ready,
        output d1,
        output d1_valid,
        input  d1_ready,
        input  y,
        input  y_valid,
        output y_ready,
        input  y_src
    );
endinterface

// File: rtl/arb_mux2_stream.sv
// Registered 2:1 stream mux with round-robin arbitration.
// One beat per cycle, fair under continuous dual valid.
module arb_mux2_stream #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic rst_n,
    arb_mux2_stream_if.slave bus
);
    logic [width-1:0] y_q;
    logic             y_valid_q;
    logic             y_src_q;
    logic             last_q;

    logic [width-1:0] y_d;
    logic             y_valid_d;
    logic             y_src_d;
    logic             last_d;

    logic load;
    logic any;
    logic gsel;

    // Grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gsel = 1'b0;
        unique case (1'b1)
            bus.d0_valid & bus.d1_valid:  gsel = ~last_q;
            bus.d0_valid & ~bus.d1_valid: gsel = 1'b0;
            ~bus.d0_valid & bus.d1_valid: gsel = 1'b1;
            default:                      gsel = 1'b0;
        endcase
    end

    assign any  = bus.d0_valid | bus.d1_valid;
    assign load = ~y_valid_q | bus.y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_src_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_src_q   <= y_src_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_src_d   = y_src_q;
        last_d    = last_q;
        if (load) begin
            y_valid_d = any;
            if (any) begin
                y_d     = gsel ? bus.d1 : bus.d0;
                y_src_d = gsel;
                last_d  = gsel;
            end
        end
    end

    // Readys are masked while reset is held so no beat is lost into reset.
    always_comb begin
        bus.d0_ready = rst_n & load & any & ~gsel;
        bus.d1_ready = rst_n & load & any & gsel;
        bus.y        = y_q;
        bus.y_valid  = y_valid_q;
        bus.y_src    = y_src_q;
    end
endmodule

// File: tb/tb_arb_mux2_stream.sv
// Scoreboard bench for arb_mux2_stream: queue-based sources and model,
// independent monitor on the output handshake.
module tb_arb_mux2_stream;
    typedef struct {
        logic       src;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_mux2_stream_if #(.width(8))  bus ();
    arb_mux2_stream_if #(.width(12)) bus12 ();

    arb_mux2_stream #(.width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    arb_mux2_stream #(.width(12)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12)
    );

    int checks = 0;
    int errors = 0;

    beat_t      exp_q[$];
    beat_t      seen_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit         m_full = 1'b0;
    bit         m_last = 1'b1;
    bit         m_src  = 1'b0;
    logic [7:0] m_y    = 8'h00;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock of stimulus plus reference model step.
    task automatic cycle(bit en0, bit en1, bit yr);
        bit v0, v1, load, g0, g1;
        beat_t b;
        v0 = en0 && (q0.size() > 0);
        v1 = en1 && (q1.size() > 0);
        bus.d0_valid = v0;
        bus.d1_valid = v1;
        bus.d0 = v0 ? q0[0] : 8'($urandom);
        bus.d1 = v1 ? q1[0] : 8'($urandom);
        bus.y_ready = yr;
        @(negedge clk);
        chk("y_valid", 32'(bus.y_valid), 32'(m_full));
        chk("y_hold", 32'(bus.y), 32'(m_y));
        chk("y_src_hold", 32'(bus.y_src), 32'(m_src));
        load = !m_full || yr;
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
        chk("d0_ready", 32'(bus.d0_ready), 32'(load && g0));
        chk("d1_ready", 32'(bus.d1_ready), 32'(load && g1));
        if (load) begin
            if (g0 || g1) begin
                b.src  = g1;
                b.data = g1 ? q1.pop_front() : q0.pop_front();
                exp_q.push_back(b);
                m_y    = b.data;
                m_src  = b.src;
                m_last = b.src;
                m_full = 1'b1;
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (6) cycle(1'b1, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got beat %0h, expected none", bus.y);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(bus.y), 32'(e.data));
                chk("sb_src", 32'(bus.y_src), 32'(e.src));
            end
            e.src  = bus.y_src;
            e.data = bus.y;
            seen_q.push_back(e);
        end
    end

    initial begin
        logic [7:0] rr_d[6];
        bit         rr_s[6];
        rr_d = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        rr_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.d0 = 8'h5A;
        bus.d1 = 8'hC3;
        bus.d0_valid = 1'b1;
        bus.d1_valid = 1'b1;
        bus.y_ready = 1'b1;
        bus12.d0 = '0;
        bus12.d1 = '0;
        bus12.d0_valid = 1'b0;
        bus12.d1_valid = 1'b0;
        bus12.y_ready = 1'b1;

        // Reset held with both sources requesting
        repeat (2) @(negedge clk);
        chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_y_src", 32'(bus.y_src), 32'd0);
        chk("rst_d0_ready", 32'(bus.d0_ready), 32'd0);
        chk("rst_d1_ready", 32'(bus.d1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin right after reset: d0 wins the first tie
        q0 = '{8'h10, 8'h11, 8'h12};
        q1 = '{8'h20, 8'h21, 8'h22};
        seen_q.delete();
        repeat (7) cycle(1'b1, 1'b1, 1'b1);
        chk("rr_count", 32'(seen_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seen_q.size()) begin
                chk("rr_data", 32'(seen_q[i].data), 32'(rr_d[i]));
                chk("rr_src", 32'(seen_q[i].src), 32'(rr_s[i]));
            end
        end

        // Single beat latency
        q0.push_back(8'hA5);
        cycle(1'b1, 1'b0, 1'b1);
        chk("single_y", 32'(bus.y), 32'hA5);
        chk("single_valid", 32'(bus.y_valid), 32'd1);
        chk("single_src", 32'(bus.y_src), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("single_drop", 32'(bus.y_valid), 32'd0);

        // Backpressure with both requesting
        q0.push_back(8'h33);
        cycle(1'b1, 1'b0, 1'b1);
        q0.push_back(8'h44);
        q1.push_back(8'h55);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        chk("bp_hold", 32'(bus.y), 32'h33);
        cycle(1'b1, 1'b1, 1'b1);
        chk("bp_reload", 32'(bus.y), 32'h55);
        chk("bp_src", 32'(bus.y_src), 32'd1);
        flush();

        // Pointer memory in both directions
        q1.push_back(8'h61);
        cycle(1'b0, 1'b1, 1'b1);
        q0.push_back(8'h70);
        q1.push_back(8'h71);
        cycle(1'b1, 1'b1, 1'b1);
        chk("ptr_d0_y", 32'(bus.y), 32'h70);
        chk("ptr_d0_src", 32'(bus.y_src), 32'd0);
        flush();
        q0.push_back(8'h80);
        cycle(1'b1, 1'b0, 1'b1);
        q0.push_back(8'h81);
        q1.push_back(8'h90);
        cycle(1'b1, 1'b1, 1'b1);
        chk("ptr_d1_y", 32'(bus.y), 32'h90);
        chk("ptr_d1_src", 32'(bus.y_src), 32'd1);
        flush();

        // Random traffic
        repeat (1500) begin
            if (q0.size() < 3 && $urandom_range(1) == 1)
                q0.push_back(8'($urandom));
            if (q1.size() < 3 && $urandom_range(1) == 1)
                q1.push_back(8'($urandom));
            cycle($urandom_range(3) != 0, $urandom_range(3) != 0,
                  $urandom_range(3) != 0);
        end
        flush();

        // Asynchronous reset while a beat is held
        q0.push_back(8'hC3);
        cycle(1'b1, 1'b0, 1'b0);
        chk("ar_pre_valid", 32'(bus.y_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.y_valid), 32'd0);
        chk("ar_y", 32'(bus.y), 32'd0);
        exp_q.delete();
        q0.delete();
        q1.delete();
        m_full = 1'b0;
        m_last = 1'b1;
        m_src = 1'b0;
        m_y = 8'h00;
        bus.d0_valid = 1'b0;
        bus.d1_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(8'hA1);
        q1.push_back(8'hB1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("ar_tie_y", 32'(bus.y), 32'hA1);
        chk("ar_tie_src", 32'(bus.y_src), 32'd0);
        flush();

        // Wider instance passes data unchanged
        bus12.d0 = 12'hABC;
        bus12.d0_valid = 1'b1;
        @(negedge clk);
        chk("w12_ready", 32'(bus12.d0_ready), 32'd1);
        @(posedge clk);
        #1;
        bus12.d0_valid = 1'b0;
        bus12.d0 = 12'h123;
        chk("w12_y", 32'(bus12.y), 32'hABC);
        chk("w12_valid", 32'(bus12.y_valid), 32'd1);
        chk("w12_src", 32'(bus12.y_src), 32'd0);
        @(posedge clk);
        #1;
        chk("w12_drop", 32'(bus12.y_valid), 32'd0);
        chk("w12_keep", 32'(bus12.y), 32'hABC);

        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_mux2_stream.md
Name: arb_mux2_stream

Overview:
- Registered 2:1 stream multiplexer with round-robin arbitration between two valid/ready sources.
- Sits directly upstream of the team's combinational 2:1 `mux2` datapath usage. It replaces a free-running select with handshake-driven selection.
- It generates the select internally, picks one beat per cycle, and presents it on a single registered valid/ready output.
- Used wherever two producers share one consumer.

Parameters:
- width, 8, data bus width in bits of d0, d1 and y (must be >= 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- d0  input  width  source 0 data
- d0_valid  input  1  source 0 has a beat
- d0_ready  output  1  source 0 beat accepted this cycle when d0_valid & d0_ready
- d1  input  width  source 1 data
- d1_valid  input  1  source 1 has a beat
- d1_ready  output  1  source 1 beat accepted this cycle when d1_valid & d1_ready
- y  output  width  registered output data
- y_valid  output  1  output register holds a beat
- y_ready  input  1  consumer accepts beat when y_valid & y_ready
- y_src  output  1  source index (0/1) of the beat currently in y

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Asserting rst_n low immediately clears all state regardless of clk.
- Reset values:
  - y = 0, y_valid = 0, y_src = 0.
  - Internal last-grant pointer last = 1, so d0 wins the first tie.
- Load enable: load = !y_valid | y_ready (output register empty or draining this cycle).
- Grant (combinational from d0_valid, d1_valid, last):
  - only d0_valid -> grant 0;
  - only d1_valid -> grant 1;
  - both -> grant = !last (the source not served most recently);
  - neither -> no grant.
- Ready outputs:
  - d0_ready = load & grant0; d1_ready = load & grant1.
  - Ready never asserted to both sources in the same cycle.
  - A ready may depend on its own valid; sources must not make valid depend on ready.
- On the rising edge with load & any grant:
  - y <= granted data, y_src <= granted index, y_valid <= 1, last <= granted index.
- On the rising edge with load & no grant:
  - y_valid <= 0; y, y_src and last hold.
- With !load (y_valid & !y_ready): y, y_valid, y_src and last hold. Both readys are 0 (backpressure).
- Latency: a beat accepted in cycle N appears on y with y_valid in cycle N+1.
- Throughput: one beat per cycle with y_ready held high. Under continuous dual valid, grants strictly alternate 0,1,0,1…
- Starvation bound: a source holding valid waits at most one other-source beat after load becomes true.
- Data integrity: y changes only on a load with grant. Data is captured whole, with no width truncation or extension; d0/d1/y are all exactly width bits.
- Simultaneous drain and fill: y_valid=1 & y_ready=1 with a grant replaces the beat in the same edge, with no bubble.
- Reset mid-operation: a beat held in y is discarded (y_valid -> 0). Sources must re-present any beat not yet handshaken; beats already accepted are lost by design.
- No X propagation: with neither valid asserted, y keeps its previous value.

Test Plan:
- Reset: hold rst_n=0, drive d0_valid=d1_valid=1 -> y_valid=0, y=0, y_src=0, d0_ready=d1_ready=0. Release rst_n -> first accepted beat comes from d0.
- Single source, width=8: d0=8'hA5 valid one cycle, y_ready=1 -> d0_ready=1 in cycle N; y=8'hA5, y_valid=1, y_src=0 in cycle N+1; y_valid=0 in N+2.
- Round-robin: d0 streams 8'h10,8'h11,8'h12; d1 streams 8'h20,8'h21,8'h22; both valid, y_ready=1 -> y sequence 10,20,11,21,12,22 with y_src 0,1,0,1,0,1, no idle cycles.
- Backpressure: y holds 8'h33; y_ready=0 for 3 cycles with both valid -> y, y_src stable and d0_ready=d1_ready=0 throughout. Next beat loads on the same edge y_ready returns to 1.
- Pointer memory: grant d1 alone, then both valid -> d0 granted next. Grant d0 alone, then both valid -> d1 granted next.
- Async reset mid-stream: assert rst_n low between clk edges while y_valid=1 -> y_valid drops to 0 immediately. After release, a tie grants d0; width=12 instance passes 12'hABC unchanged.
